// File: rtl/sky130_ef_ip__rc_osc_500k_monitor.sv
// sky130_ef_ip__rc_osc_500k_monitor: enables the RC oscillator, waits a settle interval,
// then counts synchronized oscillator edges over back-to-back gate windows.
module sky130_ef_ip__rc_osc_500k_monitor #(
    parameter int GATE_W   = 16,
    parameter int CNT_W    = 12,
    parameter int SETTLE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [SETTLE_W-1:0] settle_cycles,
    input  logic [GATE_W-1:0]   gate_cycles,
    input  logic [CNT_W-1:0]    lo_thr,
    input  logic [CNT_W-1:0]    hi_thr,
    input  logic                osc_in,
    output logic                osc_ena,
    output logic [CNT_W-1:0]    count,
    output logic                valid,
    output logic                in_range,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t state, state_n;
    logic s1, s2, s3, rise;
    logic [SETTLE_W-1:0] scnt, scnt_n;
    logic [GATE_W-1:0] gcnt, gcnt_n, g_eff;
    logic [CNT_W-1:0] acc, acc_n, acc_inc, count_n;
    logic sat, sat_n, sat_inc, armed, armed_n, valid_n, in_range_n;
    assign rise = s2 & ~s3;
    assign g_eff = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
    assign acc_inc = (acc == CNT_MAX) ? CNT_MAX : acc + CNT_W'(rise);
    assign sat_inc = sat | (acc_inc == CNT_MAX);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= osc_in;
            s2 <= s1;
            s3 <= s2;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            scnt     <= '0;
            gcnt     <= '0;
            acc      <= '0;
            sat      <= 1'b0;
            armed    <= 1'b0;
            count    <= '0;
            valid    <= 1'b0;
            in_range <= 1'b0;
            osc_ena  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            scnt     <= scnt_n;
            gcnt     <= gcnt_n;
            acc      <= acc_n;
            sat      <= sat_n;
            armed    <= armed_n;
            count    <= count_n;
            valid    <= valid_n;
            in_range <= in_range_n;
            osc_ena  <= state_n != IDLE;
            busy     <= state_n != IDLE;
        end
    end
    // The first MEASURE cycle only loads the gate counter; every later cycle is a window cycle.
    always_comb begin
        state_n    = state;
        scnt_n     = scnt;
        gcnt_n     = gcnt;
        acc_n      = acc;
        sat_n      = sat;
        armed_n    = armed;
        count_n    = count;
        valid_n    = 1'b0;
        in_range_n = in_range;
        case (state)
            IDLE: begin
                if (en) begin
                    state_n = SETTLE;
                    scnt_n  = settle_cycles;
                end
            end
            SETTLE: begin
                if (scnt == '0) begin
                    state_n = MEASURE;
                    armed_n = 1'b0;
                end else begin
                    scnt_n = scnt - SETTLE_W'(1);
                end
            end
            MEASURE: begin
                if (!armed) begin
                    gcnt_n  = g_eff;
                    acc_n   = '0;
                    sat_n   = 1'b0;
                    armed_n = 1'b1;
                end else if (gcnt == GATE_W'(1)) begin
                    count_n    = acc_inc;
                    in_range_n = (acc_inc >= lo_thr) && (acc_inc <= hi_thr) && !sat_inc;
                    valid_n    = 1'b1;
                    gcnt_n     = g_eff;
                    acc_n      = '0;
                    sat_n      = 1'b0;
                end else begin
                    gcnt_n = gcnt - GATE_W'(1);
                    acc_n  = acc_inc;
                    sat_n  = sat_inc;
                end
            end
            default: state_n = IDLE;
        endcase
        // Dropping en discards the open window and keeps the last result.
        if (!en) begin
            state_n    = IDLE;
            armed_n    = 1'b0;
            valid_n    = 1'b0;
            count_n    = count;
            in_range_n = in_range;
        end
    end
endmodule
